dm_mmio_bridge: RTL and testbench
=================================

# dm_mmio_bridge

Memory-mapped I/O bridge between the CPU data port and the data SRAM. It forwards ordinary loads and stores unchanged to the SRAM. It decodes a small register window at the top of the address space and returns register contents on loads. It latches the program-completion flag so the bench and synthesis runs can observe end of test, run length and answer-region store activity without probing SRAM internals.

## Interface
Parameters:
- MMIO_BASE, 16'hFF00: base of the 256-byte register window.
- ANS_BASE, 16'h9000: first byte of the answer region.
- ANS_WORDS, 48: answer region size in 32-bit words.
- WDOG_LIMIT, 100000: watchdog timeout in cycles. Only used when the watchdog is compiled in.

Ports:
- clk, in, 1: single clock. All state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- dm_w_en, in, 4: CPU byte write enables. Bit n writes byte lane n.
- dm_address, in, 16: CPU byte address. Word-aligned for register accesses.
- dm_write_data, in, 32: CPU store data.
- dm_read_data, out, 32: load data returned to the CPU.
- sram_w_en, out, 4: byte write enables to the SRAM.
- sram_address, out, 16: address to the SRAM.
- sram_write_data, out, 32: store data to the SRAM.
- sram_read_data, in, 32: SRAM read data. Valid one cycle after its address.
- halt, out, 1: sticky end-of-program flag.
- cycle_count, out, 32: CYCLE register value.
- store_count, out, 16: STORES register value.
- wdog_timeout, out, 1: sticky watchdog flag. Tied 0 without the macro.

## Operation
- Window hit: dm_address[15:8] == MMIO_BASE[15:8].
  - Addresses outside the window pass straight through to the SRAM: address, data and w_en, combinationally.
- Register map (offset from MMIO_BASE):
  - 0x00 CYCLE: read-only. Increments every cycle while halt==0 and wraps at 2^32.
  - 0x04 STORES: read-only, 16 bits, zero-extended on read. Counts cycles with dm_w_en!=0 and address in [ANS_BASE, ANS_BASE+4*ANS_WORDS). It saturates at 16'hFFFF.
  - 0x08 SCRATCH: read/write, 32 bits, byte-lane writes honoured.
  - 0xFC HALT: a write with dm_w_en[0]==1 and dm_write_data[7:0]==8'hFF sets halt. Reads return {31'b0, halt}.
- Write forwarding for window hits:
  - HALT writes are also forwarded to the SRAM unmodified, so the SRAM byte at 0xFFFC becomes 8'hFF.
  - All other window writes drive sram_w_en = 4'b0000.
  - Writes to read-only or unmapped offsets are dropped.
- Loads:
  - A registered select, rd_sel, captures the window hit and the offset.
  - On the next cycle, dm_read_data comes from the register mux when rd_sel indicates a window hit. Otherwise it is sram_read_data.
  - Unmapped offsets read 32'h0.
- Halt is sticky until rst. Once halted, CYCLE freezes; STORES, SCRATCH and forwarding keep working.

## Timing
- Reset values (the cycle after rst is sampled high):
  - Outputs: halt=0, cycle_count=0, store_count=0, wdog_timeout=0, dm_read_data=0.
  - Internal state: SCRATCH=0, rd_sel=pass-through.
- Forwarding paths have zero added latency.
- Load latency is 1 cycle, matching the SRAM.
- Register writes are visible to a load issued on the following cycle.
- Write-then-read of the same register:
  - A load in cycle N+1 after a write in cycle N returns the new value.
  - A load and a write in the same cycle return the old value.
- CYCLE:
  - The halting write cycle still increments it.
  - It holds from the next cycle onward.
- rst asserted mid-operation clears all state in the same edge, regardless of pending loads.

## Configuration
- DM_BRIDGE_WATCHDOG_EN:
  - Defined: adds a 32-bit watchdog counter that counts cycles while halt==0. When it reaches WDOG_LIMIT, wdog_timeout sets (sticky until rst) and halt is forced to 1. Offset 0x10 WDOG reads {wdog_timeout, counter[30:0]}.
  - Undefined: no counter, wdog_timeout tied 0, offset 0x10 reads 0.

## Structure
- Shared package dm_bridge_pkg:
  - Register offset constants (OFF_CYCLE, OFF_STORES, OFF_SCRATCH, OFF_WDOG, OFF_HALT).
  - HALT_MAGIC = 8'hFF.
  - rd_sel enum (PASS, REG).
- One sub-module, dm_bridge_regs: holds the register file, counters and the read mux. The top level holds decode, forwarding and rd_sel.

## Test plan
- Reset, then load 0xFF00 at cycles 1 and 11 -> returned values differ by exactly 10. halt=0.
- Store 32'hDEADBEEF to 0x9000 with w_en=4'hF, then load 0x9000 -> SRAM holds DEADBEEF, load returns it, store_count=1. A store to 0x90C0 leaves store_count=1.
- Write SCRATCH 32'h11223344, then w_en=4'b0010 with data 32'h0000AA00 -> SCRATCH reads 32'h1122AA44. sram_w_en stayed 0 both cycles.
- Write 8'hFF to 0xFFFC with w_en=4'b0001 -> halt=1 the next cycle, SRAM byte 0xFFFC=8'hFF, cycle_count constant for 20 cycles. A write of 8'hFE instead leaves halt=0.
- Assert rst for 1 cycle while halted with a pending load of 0xFF08 -> all outputs return to reset values. The next load returns 0.
- With DM_BRIDGE_WATCHDOG_EN and WDOG_LIMIT=50, never halt -> wdog_timeout=1 and halt=1 at cycle 50. Without the macro, wdog_timeout stays 0.

Source files
------------

// File: rtl/dm_bridge_pkg.sv
// Shared constants and types for the data-memory MMIO bridge.
// Register offsets are byte offsets from the window base.
package dm_bridge_pkg;

    localparam logic [7:0] OFF_CYCLE   = 8'h00;
    localparam logic [7:0] OFF_STORES  = 8'h04;
    localparam logic [7:0] OFF_SCRATCH = 8'h08;
    localparam logic [7:0] OFF_WDOG    = 8'h10;
    localparam logic [7:0] OFF_HALT    = 8'hFC;

    localparam logic [7:0] HALT_MAGIC  = 8'hFF;

    typedef enum logic {
        PASS = 1'b0,
        REG  = 1'b1
    } rd_sel_e;

endpackage

// File: rtl/dm_bridge_regs.sv
// Register file, run counters and registered read mux for the MMIO bridge.
// Optional watchdog is compiled in with DM_BRIDGE_WATCHDOG_EN.
module dm_bridge_regs
    import dm_bridge_pkg::*;
#(
    parameter int WDOG_LIMIT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic [7:0]  off,
    input  logic [3:0]  w_en,
    input  logic [31:0] write_data,
    input  logic        store_hit,
    output logic [31:0] rdata,
    output logic        halt,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count,
    output logic        wdog_timeout
);

    logic [31:0] cycle_reg;
    logic [15:0] store_reg;
    logic        halt_reg;
    logic [31:0] scratch;
    logic [31:0] rdata_reg;
    logic [31:0] rd_mux;
    logic        scratch_wr;
    logic        halt_set;

    assign scratch_wr = hit && (off == OFF_SCRATCH);
    assign halt_set   = hit && (off == OFF_HALT) && w_en[0] && (write_data[7:0] == HALT_MAGIC);

    for (genvar gi = 0; gi < 4; gi++) begin : g_scratch_lane
        logic [7:0] lane_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg <= '0;
            end else if (scratch_wr && w_en[gi]) begin
                lane_reg <= write_data[gi*8 +: 8];
            end
        end
        assign scratch[gi*8 +: 8] = lane_reg;
    end

`ifdef DM_BRIDGE_WATCHDOG_EN
    logic [31:0] wdog_cnt_reg;
    logic        wdog_timeout_reg;
    logic [31:0] wdog_cnt_next;

    assign wdog_cnt_next = wdog_cnt_reg + 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_reg     <= '0;
            wdog_timeout_reg <= 1'b0;
        end else if (!halt_reg) begin
            wdog_cnt_reg <= wdog_cnt_next;
            if (wdog_cnt_next == 32'(WDOG_LIMIT)) begin
                wdog_timeout_reg <= 1'b1;
            end
        end
    end

    assign wdog_timeout = wdog_timeout_reg;
`else
    assign wdog_timeout = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_CYCLE:   rd_mux = cycle_reg;
            OFF_STORES:  rd_mux = {16'h0000, store_reg};
            OFF_SCRATCH: rd_mux = scratch;
            OFF_HALT:    rd_mux = {31'b0, halt_reg};
`ifdef DM_BRIDGE_WATCHDOG_EN
            OFF_WDOG:    rd_mux = {wdog_timeout_reg, wdog_cnt_reg[30:0]};
`endif
            default:     rd_mux = '0;
        endcase
    end

    // Read data is snapshotted in the issue cycle, so a same-cycle write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_reg <= '0;
            store_reg <= '0;
            halt_reg  <= 1'b0;
            rdata_reg <= '0;
        end else begin
            rdata_reg <= rd_mux;
            if (!halt_reg) begin
                cycle_reg <= cycle_reg + 32'd1;
            end
            if (store_hit && (store_reg != 16'hFFFF)) begin
                store_reg <= store_reg + 16'd1;
            end
            if (halt_set) begin
                halt_reg <= 1'b1;
            end
`ifdef DM_BRIDGE_WATCHDOG_EN
            if (!halt_reg && (wdog_cnt_next == 32'(WDOG_LIMIT))) begin
                halt_reg <= 1'b1;
            end
`endif
        end
    end

    assign rdata       = rdata_reg;
    assign halt        = halt_reg;
    assign cycle_count = cycle_reg;
    assign store_count = store_reg;

endmodule

// File: rtl/dm_mmio_bridge.sv
// CPU data port to SRAM bridge with a small MMIO register window at the top of memory.
// Build option DM_BRIDGE_WATCHDOG_EN adds a run-length watchdog that forces halt.
module dm_mmio_bridge
    import dm_bridge_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE  = 16'hFF00,
    parameter logic [15:0] ANS_BASE   = 16'h9000,
    parameter int          ANS_WORDS  = 48,
    parameter int          WDOG_LIMIT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dm_w_en,
    input  logic [15:0] dm_address,
    input  logic [31:0] dm_write_data,
    output logic [31:0] dm_read_data,
    output logic [3:0]  sram_w_en,
    output logic [15:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [31:0] sram_read_data,
    output logic        halt,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count,
    output logic        wdog_timeout
);

    localparam logic [16:0] ANS_LO = {1'b0, ANS_BASE};
    localparam logic [16:0] ANS_HI = {1'b0, ANS_BASE} + 17'(4 * ANS_WORDS);

    logic        hit;
    logic [7:0]  off;
    logic        store_hit;
    logic [31:0] reg_rdata;
    rd_sel_e     rd_sel_reg;
    logic        rd_live_reg;

    assign hit       = (dm_address[15:8] == MMIO_BASE[15:8]);
    assign off       = dm_address[7:0];
    assign store_hit = (dm_w_en != 4'b0000)
                    && ({1'b0, dm_address} >= ANS_LO)
                    && ({1'b0, dm_address} <  ANS_HI);

    assign sram_address    = dm_address;
    assign sram_write_data = dm_write_data;

    // Only HALT writes leak into SRAM so the end-of-test byte is visible in memory too.
    always_comb begin
        sram_w_en = dm_w_en;
        if (hit) begin
            sram_w_en = (off == OFF_HALT) ? dm_w_en : 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_reg  <= PASS;
            rd_live_reg <= 1'b0;
        end else begin
            rd_sel_reg  <= hit ? REG : PASS;
            rd_live_reg <= 1'b1;
        end
    end

    // The first cycle after reset would show a load issued during reset; mask it to zero.
    always_comb begin
        dm_read_data = '0;
        if (rd_live_reg) begin
            dm_read_data = (rd_sel_reg == REG) ? reg_rdata : sram_read_data;
        end
    end

    dm_bridge_regs #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .hit          (hit),
        .off          (off),
        .w_en         (dm_w_en),
        .write_data   (dm_write_data),
        .store_hit    (store_hit),
        .rdata        (reg_rdata),
        .halt         (halt),
        .cycle_count  (cycle_count),
        .store_count  (store_count),
        .wdog_timeout (wdog_timeout)
    );

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Directed self-checking bench for dm_mmio_bridge with a behavioural word SRAM.
// Watchdog expectations follow DM_BRIDGE_WATCHDOG_EN.
module tb_dm_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  dm_w_en;
    logic [15:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;
    logic [3:0]  sram_w_en;
    logic [15:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        halt;
    logic [31:0] cycle_count;
    logic [15:0] store_count;
    logic        wdog_timeout;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    logic [31:0] mem [0:16383];
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] w;
    int          exp_cycle;

    always #5 clk = ~clk;

    dm_mmio_bridge #(
        .MMIO_BASE  (16'hFF00),
        .ANS_BASE   (16'h9000),
        .ANS_WORDS  (48),
        .WDOG_LIMIT (50)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dm_w_en         (dm_w_en),
        .dm_address      (dm_address),
        .dm_write_data   (dm_write_data),
        .dm_read_data    (dm_read_data),
        .sram_w_en       (sram_w_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .halt            (halt),
        .cycle_count     (cycle_count),
        .store_count     (store_count),
        .wdog_timeout    (wdog_timeout)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sram_w_en[i]) mem[sram_address[15:2]][i*8 +: 8] <= sram_write_data[i*8 +: 8];
        end
        sram_read_data <= mem[sram_address[15:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-22s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic drive(input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
        dm_w_en       = we;
        dm_address    = a;
        dm_write_data = d;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ticks = 0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        sram_read_data = '0;
        rst = 1'b1;
        drive(4'h0, 16'h0000, 32'h0);
        do_reset();

        check("rst_halt", {31'b0, halt}, 32'd0);
        check("rst_cycle", cycle_count, 32'd0);
        check("rst_stores", {16'b0, store_count}, 32'd0);
        check("rst_wdog", {31'b0, wdog_timeout}, 32'd0);
        check("rst_rdata", dm_read_data, 32'd0);

        // CYCLE loads ten cycles apart
        drive(4'h0, 16'hFF00, 32'h0);
        tick();
        v1 = dm_read_data;
        check("cycle_first_load", v1, 32'd0);
        repeat (10) tick();
        v2 = dm_read_data;
        check("cycle_delta", v2 - v1, 32'd10);
        check("cycle_count_11", cycle_count, 32'd11);
        check("no_halt", {31'b0, halt}, 32'd0);

        // Answer-region stores
        drive(4'hF, 16'h9000, 32'hDEADBEEF);
        check("ans_fwd_wen", {28'b0, sram_w_en}, 32'h0000000F);
        tick();
        check("stores_1", {16'b0, store_count}, 32'd1);
        drive(4'h0, 16'h9000, 32'h0);
        tick();
        check("ans_load", dm_read_data, 32'hDEADBEEF);
        w = mem[16'h9000 >> 2];
        check("sram_9000", w, 32'hDEADBEEF);
        drive(4'hF, 16'h90C0, 32'h12345678);
        tick();
        check("stores_past_end", {16'b0, store_count}, 32'd1);
        drive(4'h1, 16'h90BC, 32'h000000AB);
        tick();
        check("stores_last_word", {16'b0, store_count}, 32'd2);
        drive(4'h0, 16'hFF04, 32'h0);
        tick();
        check("stores_reg_read", dm_read_data, 32'd2);

        // SCRATCH byte-lane writes
        drive(4'hF, 16'hFF08, 32'h11223344);
        check("scratch_wen0", {28'b0, sram_w_en}, 32'd0);
        tick();
        drive(4'b0010, 16'hFF08, 32'h0000AA00);
        check("scratch_wen1", {28'b0, sram_w_en}, 32'd0);
        tick();
        drive(4'h0, 16'hFF08, 32'h0);
        tick();
        check("scratch_lane", dm_read_data, 32'h1122AA44);
        drive(4'hF, 16'hFF08, 32'h55667788);
        tick();
        check("scratch_same_cycle", dm_read_data, 32'h1122AA44);
        drive(4'h0, 16'hFF08, 32'h0);
        tick();
        check("scratch_next_cycle", dm_read_data, 32'h55667788);

        drive(4'h0, 16'hFF20, 32'h0);
        tick();
        check("unmapped_read", dm_read_data, 32'd0);
`ifndef DM_BRIDGE_WATCHDOG_EN
        drive(4'h0, 16'hFF10, 32'h0);
        tick();
        check("wdog_off_read", dm_read_data, 32'd0);
`endif

        // HALT: wrong magic, then the real one
        drive(4'b0001, 16'hFFFC, 32'h000000FE);
        check("halt_fwd_wen", {28'b0, sram_w_en}, 32'h00000001);
        tick();
        check("halt_fe_ignored", {31'b0, halt}, 32'd0);
        drive(4'b0001, 16'hFFFC, 32'h000000FF);
        tick();
        exp_cycle = ticks;
        check("halt_set", {31'b0, halt}, 32'd1);
        check("halt_cycle", cycle_count, 32'(exp_cycle));
        w = mem[16'hFFFC >> 2];
        check("sram_fffc", {24'b0, w[7:0]}, 32'h000000FF);
        drive(4'h0, 16'hFFFC, 32'h0);
        repeat (20) tick();
        check("cycle_frozen", cycle_count, 32'(exp_cycle));
        check("halt_reg_read", dm_read_data, 32'd1);

        // Reset while halted with a pending SCRATCH load
        drive(4'h0, 16'hFF08, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ticks = 0;
        check("rst2_halt", {31'b0, halt}, 32'd0);
        check("rst2_cycle", cycle_count, 32'd0);
        check("rst2_stores", {16'b0, store_count}, 32'd0);
        check("rst2_wdog", {31'b0, wdog_timeout}, 32'd0);
        check("rst2_rdata", dm_read_data, 32'd0);
        tick();
        check("rst2_scratch_load", dm_read_data, 32'd0);

        // Watchdog run with no halting write
        do_reset();
        drive(4'h0, 16'h0000, 32'h0);
        repeat (49) tick();
        check("wdog_before_limit", {31'b0, halt}, 32'd0);
        tick();
`ifdef DM_BRIDGE_WATCHDOG_EN
        check("wdog_timeout_set", {31'b0, wdog_timeout}, 32'd1);
        check("wdog_forced_halt", {31'b0, halt}, 32'd1);
`else
        repeat (10) tick();
        check("wdog_stays_0", {31'b0, wdog_timeout}, 32'd0);
        check("wdog_no_halt", {31'b0, halt}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
